ota_duty_meter: RTL
===================

# ota_duty_meter

Digital back-end for the gate-level OTA/comparator output. Resynchronises and deglitches the asynchronous comparator decision, then measures it over fixed windows of 2^WIN_LOG2 clock cycles: duty cycle (fraction of cycles high) and rising-edge count. Each window's result is handed to the readout logic through a valid/ack handshake. It sits directly downstream of the OTA's `Out` net and feeds the tile's digital outputs.

## Interface
Parameters:
- `WIN_LOG2`, 10, log2 of the window length in cycles; requires WIN_LOG2 ≥ OUT_W.
- `OUT_W`, 8, width of the duty result.
- `FILT_LEN`, 3, number of consecutive agreeing samples needed to change the filtered level (1..15).

Ports:
- `clk` in 1: the single clock; everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: measurement enable.
- `cmp_in` in 1: OTA output, asynchronous to `clk`.
- `res_duty` out OUT_W: duty result of the last committed window.
- `res_edges` out 8: rising edges in the last committed window, saturating at 255.
- `res_valid` out 1: result pending.
- `res_ack` in 1: consumer accepts the result; only meaningful while `res_valid`=1.
- `overrun` out 1: sticky flag; a result was overwritten before it was acked.
- `lvl` out 1: filtered comparator level, for debug.

## Operation
- **Reset:** every register clears to 0: sync flops, filter, counters, `res_duty`, `res_edges`, `res_valid`, `overrun`, `lvl`. The FSM goes to IDLE.
- **Sync:** two-flop synchroniser on `cmp_in` produces `s`.
- **Filter:** an agree-counter tracks samples where `s` ≠ `lvl`.
  - When `s` ≠ `lvl` for FILT_LEN consecutive cycles, `lvl` toggles and the counter clears.
  - Any cycle with `s` = `lvl` clears the counter.
  - The filter runs regardless of `en`.
- **FSM states:**
  - IDLE: counters held at 0. If `en`=1, go to MEAS next cycle.
  - MEAS: every cycle `wcnt` increments and `hi_cnt` increments when `lvl`=1. `edge_cnt` increments (saturating at 255) when `lvl` is 1 and the previous `lvl` was 0.
  - In MEAS, if `en`=0, go to IDLE; the partial window is discarded with no commit and no flag change.
- **Commit:** on the MEAS cycle where `wcnt` = 2^WIN_LOG2−1 (that cycle's sample is included):
  - Load `res_duty` and `res_edges`.
  - Set `res_valid`.
  - Clear the counters and stay in MEAS, so windows run back to back.
- **Duty arithmetic:**
  - `hi_cnt` is WIN_LOG2+1 bits wide.
  - `res_duty` = `hi_cnt` >> (WIN_LOG2−OUT_W).
  - If `hi_cnt` = 2^WIN_LOG2, `res_duty` saturates to 2^OUT_W−1.
- **Handshake:**
  - `res_ack`=1 while `res_valid`=1 clears `res_valid` and `overrun` on the next edge.
  - `res_ack` while `res_valid`=0 is ignored.
- **Simultaneous events:**
  - Commit and ack in the same cycle: the ack consumes the old result. The new result loads, `res_valid` stays 1, and `overrun` is not set.
  - Commit while `res_valid`=1 with no ack: data is overwritten and `overrun` is set to 1. The flag holds until an ack or `rst`.
- **Reset mid-window:** all state is lost and the next window starts from IDLE.

## Timing
- `cmp_in` to `lvl`: 2 sync cycles plus FILT_LEN filter cycles (5 with defaults).
- `en` rising to the first counted sample: 1 cycle (the IDLE→MEAS transition).
- A window is exactly 2^WIN_LOG2 counted cycles.
- `res_*` outputs update on the edge after the last sample of the window.
- All outputs are registered and there are no combinational input-to-output paths.
- Throughput: one result per 2^WIN_LOG2 cycles. The consumer has that many cycles to ack before an overrun.

## Structure
- Package `ota_meter_pkg` holds:
  - the FSM state enum {IDLE, MEAS};
  - default constants for WIN_LOG2, OUT_W and FILT_LEN;
  - `EDGE_W`=8.
- Sub-module `ota_sync_filter` contains the two-flop synchroniser and the agree-counter filter. Ports: `clk`, `rst`, `cmp_in`, `lvl`.
- The top module holds the FSM, the counters, the result registers and the handshake.

## Test plan
1. `cmp_in`=1 from reset, `en`=1, ack every result:
   - first window gives `res_duty`=8'hFF and `res_edges`=1;
   - second window gives 8'hFF and 0.
2. Square wave, period 64 cycles, 50% high, steady state: `res_duty`=8'h80, `res_edges`=16, `overrun`=0.
3. `cmp_in` low with 1- and 2-cycle high glitches every 10 cycles, FILT_LEN=3: `lvl` never rises, `res_duty`=0, `res_edges`=0.
4. Constant `cmp_in`, no ack for two windows:
   - after the second commit, `overrun`=1 and `res_duty` holds the second window's value;
   - a one-cycle ack then gives `res_valid`=0 and `overrun`=0 on the next cycle.
5. Ack asserted exactly on a commit cycle: `res_valid` stays 1, `overrun` stays 0, new data is presented.
6. Mid-window events:
   - drop `en` at counted cycle 500: no `res_valid`; re-enable and the next commit comes exactly 1+1024 cycles later;
   - assert `rst` mid-window: all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/ota_meter_pkg.sv
// Shared types and default constants for the OTA comparator duty/edge meter.
package ota_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam int unsigned WIN_LOG2_DEF = 10;
    localparam int unsigned OUT_W_DEF    = 8;
    localparam int unsigned FILT_LEN_DEF = 3;
    localparam int unsigned EDGE_W       = 8;

endpackage

// File: rtl/ota_sync_filter.sv
// Two-flop synchroniser followed by an agree-counter deglitch filter.
module ota_sync_filter
    import ota_meter_pkg::*;
#(
    parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic cmp_in,
    output logic lvl
);

    logic       meta;
    logic       s;
    logic [3:0] agree;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b0;
            s     <= 1'b0;
            lvl   <= 1'b0;
            agree <= '0;
        end else begin
            meta <= cmp_in;
            s    <= meta;
            // lvl flips on the FILT_LEN-th consecutive disagreeing sample
            if (s != lvl) begin
                if (agree == 4'(FILT_LEN - 1)) begin
                    lvl   <= ~lvl;
                    agree <= '0;
                end else begin
                    agree <= agree + 4'd1;
                end
            end else begin
                agree <= '0;
            end
        end
    end

endmodule

// File: rtl/ota_duty_meter.sv
// Windowed duty-cycle and rising-edge meter for the OTA comparator output,
// with a valid/ack result handshake and sticky overrun flag.
module ota_duty_meter
    import ota_meter_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF,
    parameter int unsigned OUT_W    = OUT_W_DEF,
    parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cmp_in,
    output logic [OUT_W-1:0]  res_duty,
    output logic [EDGE_W-1:0] res_edges,
    output logic              res_valid,
    input  logic              res_ack,
    output logic              overrun,
    output logic              lvl
);

    localparam int unsigned SHIFT = WIN_LOG2 - OUT_W;

    state_t              state;
    state_t              state_nxt;
    logic [WIN_LOG2-1:0] wcnt;
    logic [WIN_LOG2:0]   hi_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic                lvl_q;

    logic                counting;
    logic                last;
    logic                rise;
    logic                ack_take;
    logic [WIN_LOG2:0]   hi_fin;
    logic [EDGE_W-1:0]   edge_fin;

    ota_sync_filter #(
        .FILT_LEN(FILT_LEN)
    ) u_filt (
        .clk    (clk),
        .rst    (rst),
        .cmp_in (cmp_in),
        .lvl    (lvl)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = MEAS;
            MEAS:    if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Final-cycle totals include the current sample so the commit sees a full window
    assign counting = (state == MEAS) && en;
    assign last     = counting && (wcnt == '1);
    assign rise     = lvl && !lvl_q;
    assign hi_fin   = hi_cnt + {{WIN_LOG2{1'b0}}, lvl};
    assign edge_fin = (rise && (edge_cnt != '1)) ? edge_cnt + 1'b1 : edge_cnt;
    assign ack_take = res_valid && res_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q    <= 1'b0;
            wcnt     <= '0;
            hi_cnt   <= '0;
            edge_cnt <= '0;
        end else begin
            lvl_q <= lvl;
            if (!counting || last) begin
                wcnt     <= '0;
                hi_cnt   <= '0;
                edge_cnt <= '0;
            end else begin
                wcnt     <= wcnt + 1'b1;
                hi_cnt   <= hi_fin;
                edge_cnt <= edge_fin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_duty  <= '0;
            res_edges <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (last) begin
                res_duty  <= hi_fin[WIN_LOG2] ? '1 : hi_fin[SHIFT +: OUT_W];
                res_edges <= edge_fin;
                res_valid <= 1'b1;
            end else if (ack_take) begin
                res_valid <= 1'b0;
            end
            // An ack in the commit cycle consumes the old result, so no overrun
            if (ack_take)
                overrun <= 1'b0;
            else if (last && res_valid)
                overrun <= 1'b1;
        end
    end

endmodule
